// File: rtl/sap_control_sequencer_pkg.sv
// Shared definitions for the SAP-1 control sequencer: opcodes, T-state
// one-hot encodings and control-word bit positions used for probe packing.
package sap_control_sequencer_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  localparam int unsigned CW_PC_INC   = 0;
  localparam int unsigned CW_PC_OUT   = 1;
  localparam int unsigned CW_PC_LOAD  = 2;
  localparam int unsigned CW_MAR_LOAD = 3;
  localparam int unsigned CW_RAM_OUT  = 4;
  localparam int unsigned CW_IR_LOAD  = 5;
  localparam int unsigned CW_IR_OUT   = 6;
  localparam int unsigned CW_A_LOAD   = 7;
  localparam int unsigned CW_A_OUT    = 8;
  localparam int unsigned CW_B_LOAD   = 9;
  localparam int unsigned CW_ALU_OUT  = 10;
  localparam int unsigned CW_ALU_SUB  = 11;
  localparam int unsigned CW_OUT_LOAD = 12;
  localparam int unsigned CW_W        = 13;

endpackage

// File: rtl/sap_control_sequencer_if.sv
// Sequencer <-> datapath bundle: opcode/ALU status in, W-bus control strobes out.
interface sap_control_sequencer_if;
  logic [3:0] ir_opcode;
  logic       alu_c;
  logic       alu_z;
  logic       pc_inc;
  logic       pc_out;
  logic       pc_load;
  logic       mar_load;
  logic       ram_out;
  logic       ir_load;
  logic       ir_out;
  logic       a_load;
  logic       a_out;
  logic       b_load;
  logic       alu_out;
  logic       alu_sub;
  logic       out_load;
  logic       halted;
  logic [5:0] t_state;
  logic [1:0] flags;

  modport master (
    input  ir_opcode, alu_c, alu_z,
    output pc_inc, pc_out, pc_load, mar_load, ram_out, ir_load, ir_out,
           a_load, a_out, b_load, alu_out, alu_sub, out_load,
           halted, t_state, flags
  );

  modport slave (
    output ir_opcode, alu_c, alu_z,
    input  pc_inc, pc_out, pc_load, mar_load, ram_out, ir_load, ir_out,
           a_load, a_out, b_load, alu_out, alu_sub, out_load,
           halted, t_state, flags
  );
endinterface

// File: rtl/sap_control_sequencer_ring_counter.sv
// One-hot T1..T6 ring with synchronous reset, hold and early wrap back to T1.
module sap_ring_counter
  import sap_control_sequencer_pkg::*;
(
  input  logic     clk,
  input  logic     rst_i,
  input  logic     hold_i,
  input  logic     wrap_i,
  output t_state_e state_o
);
  t_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst_i) state_q <= T1;
    else       state_q <= state_d;
  end

  // hold wins over wrap so a halt in T4 stays frozen even in short-cycle mode
  always_comb begin
    state_d = state_q;
    if (!hold_i) begin
      if (wrap_i) state_d = T1;
      else        state_d = t_state_e'({state_q[4:0], state_q[5]});
    end
  end

  assign state_o = state_q;
endmodule

// File: rtl/sap_control_sequencer.sv
// SAP-1 control unit: T-state ring, opcode decode to W-bus strobes, C/Z flags, halt.
// Conditional jumps (JMP/JC/JZ) are built only when SAP_COND_JUMP_EN is defined.
module sap_control_sequencer
  import sap_control_sequencer_pkg::*;
#(
  parameter bit SHORT_CYCLE = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  sap_control_sequencer_if.master   bus
);
  t_state_e          t_state;
  logic              halted_q, halted_d;
  logic [1:0]        flags_q, flags_d;
  logic [CW_W-1:0]   cw;
  logic              hold, wrap;
  logic              is_hlt_t4, is_alu_op;

  assign is_hlt_t4 = (t_state == T4) && (bus.ir_opcode == OP_HLT);
  assign is_alu_op = (bus.ir_opcode == OP_ADD) || (bus.ir_opcode == OP_SUB);
  assign hold      = halted_q || is_hlt_t4;

  // Early return: LDA is done after T5; everything except LDA/ADD/SUB after T4.
  always_comb begin
    wrap = 1'b0;
    if (SHORT_CYCLE) begin
      if (t_state == T5 && bus.ir_opcode == OP_LDA) wrap = 1'b1;
      if (t_state == T4 && bus.ir_opcode != OP_LDA && !is_alu_op) wrap = 1'b1;
    end
  end

  sap_ring_counter u_ring (
    .clk     (clk),
    .rst_i   (reset),
    .hold_i  (hold),
    .wrap_i  (wrap),
    .state_o (t_state)
  );

  always_comb begin
    halted_d = halted_q;
    flags_d  = flags_q;
    if (is_hlt_t4) halted_d = 1'b1;
    if (t_state == T6 && !halted_q && is_alu_op) flags_d = {bus.alu_c, bus.alu_z};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      halted_q <= 1'b0;
      flags_q  <= '0;
    end else begin
      halted_q <= halted_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    cw = '0;
    case (t_state)
      T1: begin cw[CW_PC_OUT] = 1'b1; cw[CW_MAR_LOAD] = 1'b1; end
      T2: cw[CW_PC_INC] = 1'b1;
      T3: begin cw[CW_RAM_OUT] = 1'b1; cw[CW_IR_LOAD] = 1'b1; end
      T4: begin
        case (bus.ir_opcode)
          OP_LDA, OP_ADD, OP_SUB: begin cw[CW_IR_OUT] = 1'b1; cw[CW_MAR_LOAD] = 1'b1; end
          OP_OUT: begin cw[CW_A_OUT] = 1'b1; cw[CW_OUT_LOAD] = 1'b1; end
`ifdef SAP_COND_JUMP_EN
          OP_JMP: begin cw[CW_IR_OUT] = 1'b1; cw[CW_PC_LOAD] = 1'b1; end
          OP_JC: if (flags_q[1]) begin cw[CW_IR_OUT] = 1'b1; cw[CW_PC_LOAD] = 1'b1; end
          OP_JZ: if (flags_q[0]) begin cw[CW_IR_OUT] = 1'b1; cw[CW_PC_LOAD] = 1'b1; end
`endif
          default: ;
        endcase
      end
      T5: begin
        if (bus.ir_opcode == OP_LDA) begin cw[CW_RAM_OUT] = 1'b1; cw[CW_A_LOAD] = 1'b1; end
        if (is_alu_op)               begin cw[CW_RAM_OUT] = 1'b1; cw[CW_B_LOAD] = 1'b1; end
      end
      T6: begin
        if (is_alu_op) begin cw[CW_ALU_OUT] = 1'b1; cw[CW_A_LOAD] = 1'b1; end
        if (bus.ir_opcode == OP_SUB) cw[CW_ALU_SUB] = 1'b1;
      end
      default: ;
    endcase
    if (reset || halted_q) cw = '0;
  end

  assign bus.pc_inc   = cw[CW_PC_INC];
  assign bus.pc_out   = cw[CW_PC_OUT];
  assign bus.pc_load  = cw[CW_PC_LOAD];
  assign bus.mar_load = cw[CW_MAR_LOAD];
  assign bus.ram_out  = cw[CW_RAM_OUT];
  assign bus.ir_load  = cw[CW_IR_LOAD];
  assign bus.ir_out   = cw[CW_IR_OUT];
  assign bus.a_load   = cw[CW_A_LOAD];
  assign bus.a_out    = cw[CW_A_OUT];
  assign bus.b_load   = cw[CW_B_LOAD];
  assign bus.alu_out  = cw[CW_ALU_OUT];
  assign bus.alu_sub  = cw[CW_ALU_SUB];
  assign bus.out_load = cw[CW_OUT_LOAD];
  assign bus.halted   = halted_q;
  assign bus.t_state  = t_state;
  assign bus.flags    = flags_q;
endmodule

// File: tb/tb_sap_control_sequencer.sv
// Randomized scoreboard bench: two sequencers (SHORT_CYCLE 0 and 1) against a step-count reference model.
module tb_sap_control_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sap_control_sequencer_if if0 ();
  sap_control_sequencer_if if1 ();

  sap_control_sequencer #(.SHORT_CYCLE(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  sap_control_sequencer #(.SHORT_CYCLE(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  // Strobe masks in bench order: named micro-operations.
  localparam logic [12:0] S_PC_INC = 13'h0001, S_PC_OUT = 13'h0002, S_PC_LOAD = 13'h0004,
    S_MAR_LOAD = 13'h0008, S_RAM_OUT = 13'h0010, S_IR_LOAD = 13'h0020, S_IR_OUT = 13'h0040,
    S_A_LOAD = 13'h0080, S_A_OUT = 13'h0100, S_B_LOAD = 13'h0200, S_ALU_OUT = 13'h0400,
    S_ALU_SUB = 13'h0800, S_OUT_LOAD = 13'h1000;

  typedef logic [21:0] rec_t;  // {t_state[5:0], strobes[12:0], halted, flags[1:0]}

  rec_t sb0[$];
  rec_t sb1[$];
  int checks = 0;
  int failures = 0;

  int         step[2];
  logic       hm[2];
  logic [1:0] fm[2];
  logic [3:0] opm[2];
  int         hcnt[2];
  logic       rst_a, c_a, z_a;

  function automatic logic [12:0] micro_ops(int s, logic [3:0] op, logic [1:0] fl);
    logic [12:0] m = '0;
    case (s)
      1: m = S_PC_OUT | S_MAR_LOAD;
      2: m = S_PC_INC;
      3: m = S_RAM_OUT | S_IR_LOAD;
      4: begin
        if (op == 4'd0 || op == 4'd1 || op == 4'd2) m = S_IR_OUT | S_MAR_LOAD;
        else if (op == 4'd14) m = S_A_OUT | S_OUT_LOAD;
`ifdef SAP_COND_JUMP_EN
        else if (op == 4'd6 || (op == 4'd7 && fl[1]) || (op == 4'd8 && fl[0])) m = S_IR_OUT | S_PC_LOAD;
`endif
      end
      5: begin
        if (op == 4'd0) m = S_RAM_OUT | S_A_LOAD;
        else if (op == 4'd1 || op == 4'd2) m = S_RAM_OUT | S_B_LOAD;
      end
      6: begin
        if (op == 4'd1) m = S_ALU_OUT | S_A_LOAD;
        else if (op == 4'd2) m = S_ALU_OUT | S_A_LOAD | S_ALU_SUB;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic int last_step(int k, logic [3:0] op);
    if (k == 0) return 6;
    if (op == 4'd0) return 5;
    if (op == 4'd1 || op == 4'd2) return 6;
    return 4;
  endfunction

  task automatic model_edge(int k);
    if (rst_a) begin
      step[k] = 1; hm[k] = 1'b0; fm[k] = 2'b00; hcnt[k] = 0;
    end else if (hm[k]) begin
      hcnt[k] = hcnt[k] + 1;
    end else if (step[k] == 4 && opm[k] == 4'd15) begin
      hm[k] = 1'b1; hcnt[k] = 0;
    end else begin
      if (step[k] == 6 && (opm[k] == 4'd1 || opm[k] == 4'd2)) fm[k] = {c_a, z_a};
      step[k] = (step[k] >= last_step(k, opm[k])) ? 1 : step[k] + 1;
    end
  endtask

  function automatic rec_t expect_rec(int k);
    logic [12:0] m;
    logic [5:0]  t;
    m = (rst_a || hm[k]) ? 13'd0 : micro_ops(step[k], opm[k], fm[k]);
    t = 6'd1 << (step[k] - 1);
    return {t, m, hm[k], fm[k]};
  endfunction

  task automatic compare(string name, rec_t exp_r, rec_t act_r);
    checks = checks + 1;
    if (exp_r !== act_r) begin
      failures = failures + 1;
      $display("FAIL %s t=%0t actual t_state=%b strobes=%h halted=%b flags=%b required t_state=%b strobes=%h halted=%b flags=%b",
               name, $time, act_r[21:16], act_r[15:3], act_r[2], act_r[1:0],
               exp_r[21:16], exp_r[15:3], exp_r[2], exp_r[1:0]);
    end
  endtask

  always @(negedge clk) begin
    if (sb0.size() > 0)
      compare("dut0_short0", sb0.pop_front(),
        {if0.t_state, if0.out_load, if0.alu_sub, if0.alu_out, if0.b_load, if0.a_out, if0.a_load,
         if0.ir_out, if0.ir_load, if0.ram_out, if0.mar_load, if0.pc_load, if0.pc_out, if0.pc_inc,
         if0.halted, if0.flags});
    if (sb1.size() > 0)
      compare("dut1_short1", sb1.pop_front(),
        {if1.t_state, if1.out_load, if1.alu_sub, if1.alu_out, if1.b_load, if1.a_out, if1.a_load,
         if1.ir_out, if1.ir_load, if1.ram_out, if1.mar_load, if1.pc_load, if1.pc_out, if1.pc_inc,
         if1.halted, if1.flags});
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      step[k] = 1; hm[k] = 1'b0; fm[k] = 2'b00; opm[k] = 4'd0; hcnt[k] = 0;
    end
    rst_a = 1'b1; c_a = 1'b0; z_a = 1'b0;
    reset = 1'b1;
    if0.ir_opcode = 4'd0; if1.ir_opcode = 4'd0;
    if0.alu_c = 1'b0; if0.alu_z = 1'b0; if1.alu_c = 1'b0; if1.alu_z = 1'b0;

    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        model_edge(k);
        if (step[k] == 1 && !hm[k]) opm[k] = 4'($urandom_range(0, 15));
      end
      rst_a = (n < 2) || ($urandom_range(0, 63) == 0) ||
              (hm[0] && hcnt[0] >= 10) || (hm[1] && hcnt[1] >= 10);
      c_a = 1'($urandom_range(0, 1));
      z_a = 1'($urandom_range(0, 1));
      reset = rst_a;
      if0.ir_opcode = opm[0]; if1.ir_opcode = opm[1];
      if0.alu_c = c_a; if0.alu_z = z_a; if1.alu_c = c_a; if1.alu_z = z_a;
      sb0.push_back(expect_rec(0));
      sb1.push_back(expect_rec(1));
    end

    @(negedge clk);
    #1;
    checks = checks + 1;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_drain actual pending=%0d required pending=0", sb0.size() + sb1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
